// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs register fields and a sign-extended
// immediate into one instruction word, range-checks the immediate, and
// tags each legal word with an auto-incrementing imem word address.
// Ports:
//   clk, rst                  clock, async active-high reset
//   in_valid/in_ready         input handshake
//   imm_type                  001 I, 010 B, 011 S, 100 J, 101 U, else R
//   opcode..rs2, imm          instruction fields, full byte-offset imm
//   base_load/base_addr       reload the address counter
//   clr_err                   clear err and err_cnt
//   out_valid/out_ready       output handshake
//   out_inst/out_addr         encoded word and its write address
//   err/err_cnt               sticky reject flag, saturating reject count
//   word_cnt                  words emitted since reset, saturating
module inst_encoder #(
   parameter int ADDR_W   = 8,
   parameter int ERRCNT_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [2:0]          imm_type,
   input  logic [6:0]          opcode,
   input  logic [2:0]          funct3,
   input  logic [6:0]          funct7,
   input  logic [4:0]          rd,
   input  logic [4:0]          rs1,
   input  logic [4:0]          rs2,
   input  logic [31:0]         imm,
   input  logic                base_load,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic                clr_err,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [31:0]         out_inst,
   output logic [ADDR_W-1:0]   out_addr,
   output logic                err,
   output logic [ERRCNT_W-1:0] err_cnt,
   output logic [ADDR_W:0]     word_cnt
);

   logic                out_valid_q, out_valid_d;
   logic [31:0]         out_inst_q, out_inst_d;
   logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                err_q, err_d;
   logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [ADDR_W:0]     word_cnt_q, word_cnt_d;

   logic [31:0] enc;
   logic        legal;
   logic        accept;
   logic        hs_out;
   logic        sx11, sx12, sx20;

   // Upper immediate bits all copies of the sign bit
   assign sx11 = (&imm[31:11]) | ~(|imm[31:11]);
   assign sx12 = (&imm[31:12]) | ~(|imm[31:12]);
   assign sx20 = (&imm[31:20]) | ~(|imm[31:20]);

   always_comb begin
      enc   = '0;
      legal = 1'b1;
      unique case (imm_type)
         3'b001: begin
            enc   = {imm[11:0], rs1, funct3, rd, opcode};
            legal = sx11;
         end
         3'b011: begin
            enc   = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            legal = sx11;
         end
         3'b010: begin
            enc   = {imm[12], imm[10:5], rs2, rs1, funct3,
                     imm[4:1], imm[11], opcode};
            legal = sx12 & ~imm[0];
         end
         3'b100: begin
            enc   = {imm[20], imm[10:1], imm[11], imm[19:12],
                     rd, opcode};
            legal = sx20 & ~imm[0];
         end
         3'b101: begin
            enc   = {imm[31:12], rd, opcode};
            legal = ~(|imm[11:0]);
         end
         default: begin
            enc   = {funct7, rs2, rs1, funct3, rd, opcode};
            legal = 1'b1;
         end
      endcase
   end

   assign in_ready = ~out_valid_q | out_ready;
   assign accept   = in_valid & in_ready;
   assign hs_out   = out_valid_q & out_ready;

   always_comb begin
      out_valid_d = out_valid_q;
      out_inst_d  = out_inst_q;
      out_addr_d  = out_addr_q;
      addr_d      = addr_q;
      err_d       = err_q;
      err_cnt_d   = err_cnt_q;
      word_cnt_d  = word_cnt_q;
      if (hs_out) begin
         out_valid_d = 1'b0;
         if (word_cnt_q != '1)
            word_cnt_d = word_cnt_q + (ADDR_W+1)'(1);
      end
      if (clr_err) begin
         err_d     = 1'b0;
         err_cnt_d = '0;
      end
      if (accept) begin
         if (legal) begin
            out_valid_d = 1'b1;
            out_inst_d  = enc;
            out_addr_d  = addr_q;
            addr_d      = addr_q + ADDR_W'(1);
         end else begin
            // A reject in the same cycle as clr_err still counts
            err_d = 1'b1;
            if (clr_err)
               err_cnt_d = ERRCNT_W'(1);
            else if (err_cnt_q != '1)
               err_cnt_d = err_cnt_q + ERRCNT_W'(1);
         end
      end
      // Load wins over increment; captured word used the old value
      if (base_load)
         addr_d = base_addr;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_inst_q  <= '0;
         out_addr_q  <= '0;
         addr_q      <= '0;
         err_q       <= 1'b0;
         err_cnt_q   <= '0;
         word_cnt_q  <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_inst_q  <= out_inst_d;
         out_addr_q  <= out_addr_d;
         addr_q      <= addr_d;
         err_q       <= err_d;
         err_cnt_q   <= err_cnt_d;
         word_cnt_q  <= word_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_inst  = out_inst_q;
   assign out_addr  = out_addr_q;
   assign err       = err_q;
   assign err_cnt   = err_cnt_q;
   assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: directed encodings plus random
// fields checked against a behavioural encoder/range model.
module tb_inst_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  imm_type;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] imm;
   logic        base_load;
   logic [7:0]  base_addr;
   logic        clr_err;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [7:0]  out_addr;
   logic        err;
   logic [7:0]  err_cnt;
   logic [8:0]  word_cnt;

   inst_encoder #(.ADDR_W(8), .ERRCNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .imm_type(imm_type), .opcode(opcode),
      .funct3(funct3), .funct7(funct7),
      .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
      .base_load(base_load), .base_addr(base_addr),
      .clr_err(clr_err),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_inst(out_inst), .out_addr(out_addr),
      .err(err), .err_cnt(err_cnt), .word_cnt(word_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // expected words: {addr, inst}
   logic [39:0] sb_q[$];

   logic [7:0] m_addr;
   bit         m_err;
   int         m_err_cnt;
   int         m_pushed;
   bit         rnd_ready = 0;

   function automatic bit m_legal(logic [2:0] t, logic [31:0] v);
      int s;
      s = $signed(v);
      case (t)
         3'd1, 3'd3: return (s >= -2048) && (s <= 2047);
         3'd2: return (s >= -4096) && (s <= 4095) && (v % 2 == 0);
         3'd4: return (s >= -1048576) && (s <= 1048575)
                      && (v % 2 == 0);
         3'd5: return (v % 4096) == 0;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] m_enc(
      logic [2:0] t, logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
      logic [4:0] d, logic [4:0] s1, logic [4:0] s2, logic [31:0] v);
      logic [31:0] r;
      r = 32'(op);
      case (t)
         3'd1: r = r | ((v & 32'hFFF) << 20) | (32'(s1) << 15)
                     | (32'(f3) << 12) | (32'(d) << 7);
         3'd3: r = r | (((v >> 5) & 32'h7F) << 25) | (32'(s2) << 20)
                     | (32'(s1) << 15) | (32'(f3) << 12)
                     | ((v & 32'h1F) << 7);
         3'd2: r = r | (((v >> 12) & 32'h1) << 31)
                     | (((v >> 5) & 32'h3F) << 25)
                     | (32'(s2) << 20) | (32'(s1) << 15)
                     | (32'(f3) << 12) | (((v >> 1) & 32'hF) << 8)
                     | (((v >> 11) & 32'h1) << 7);
         3'd4: r = r | (((v >> 20) & 32'h1) << 31)
                     | (((v >> 1) & 32'h3FF) << 21)
                     | (((v >> 11) & 32'h1) << 20)
                     | (((v >> 12) & 32'hFF) << 12) | (32'(d) << 7);
         3'd5: r = r | (v & 32'hFFFFF000) | (32'(d) << 7);
         default: r = r | (32'(f7) << 25) | (32'(s2) << 20)
                        | (32'(s1) << 15) | (32'(f3) << 12)
                        | (32'(d) << 7);
      endcase
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      sb_q.delete();
      m_addr    = 8'h00;
      m_err     = 0;
      m_err_cnt = 0;
      m_pushed  = 0;
   endtask

   // Hold in_valid until accepted, then apply the model.
   task automatic wait_accept(input bit use_exp,
                              input logic [31:0] exp_inst);
      bit done;
      logic [31:0] e;
      done = 0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            done = 1;
            if (clr_err) begin
               m_err     = 0;
               m_err_cnt = 0;
            end
            if (m_legal(imm_type, imm)) begin
               e = use_exp ? exp_inst
                  : m_enc(imm_type, opcode, funct3, funct7,
                          rd, rs1, rs2, imm);
               sb_q.push_back({m_addr, e});
               m_addr = m_addr + 8'd1;
               m_pushed++;
            end else begin
               m_err = 1;
               if (m_err_cnt < 255) m_err_cnt++;
            end
            if (base_load) m_addr = base_addr;
         end
      end
      step();
      in_valid  = 0;
      base_load = 0;
      clr_err   = 0;
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout got=no_accept expected=accept");
      end
   endtask

   task automatic drive(input logic [2:0] t, input logic [6:0] op,
                        input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [31:0] v);
      imm_type = t; opcode = op; funct3 = f3; funct7 = f7;
      rd = d; rs1 = s1; rs2 = s2; imm = v;
      in_valid = 1;
   endtask

   task automatic send(input logic [2:0] t, input logic [6:0] op,
                       input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [31:0] v,
                       input bit use_exp, input logic [31:0] ex);
      drive(t, op, f3, f7, d, s1, s2, v);
      wait_accept(use_exp, ex);
   endtask

   task automatic load_base(input logic [7:0] a);
      base_load = 1;
      base_addr = a;
      step();
      base_load = 0;
      m_addr = a;
   endtask

   task automatic pulse_clr();
      clr_err = 1;
      step();
      clr_err = 0;
      m_err = 0;
      m_err_cnt = 0;
   endtask

   task automatic drain();
      bit done;
      done = 0;
      out_ready = 1;
      for (int i = 0; i < 200 && !done; i++) begin
         if (sb_q.size() == 0 && !out_valid) done = 1;
         else step();
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout got=pending expected=empty");
      end
   endtask

   task automatic send_rand();
      logic [31:0] v;
      case ($urandom_range(0, 3))
         0: v = $urandom;
         1: v = 32'($urandom_range(0, 8191)) - 32'd4096;
         2: v = $urandom & 32'hFFFFF000;
         default: v = 32'($urandom_range(0, 4194303)) - 32'd2097152;
      endcase
      send(3'($urandom_range(0, 7)), 7'($urandom),
           3'($urandom), 7'($urandom), 5'($urandom),
           5'($urandom), 5'($urandom), v, 0, 32'h0);
   endtask

   // Monitor: pop and compare on every output handshake
   initial begin
      logic [39:0] e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            n_checks++;
            if (sb_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_word got=%h@%h expected=none",
                        out_inst, out_addr);
            end else begin
               e = sb_q.pop_front();
               if (out_inst !== e[31:0] || out_addr !== e[39:32]) begin
                  n_fail++;
                  $display("FAIL out_word got=%h@%h expected=%h@%h",
                           out_inst, out_addr, e[31:0], e[39:32]);
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1; in_valid = 0; imm_type = 0; opcode = 0; funct3 = 0;
      funct7 = 0; rd = 0; rs1 = 0; rs2 = 0; imm = 0;
      base_load = 0; base_addr = 0; clr_err = 0; out_ready = 1;
      model_reset();
      #12;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_inst", out_inst, 0);
      chk("rst_out_addr", 32'(out_addr), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_err_cnt", 32'(err_cnt), 0);
      chk("rst_word_cnt", 32'(word_cnt), 0);
      step();
      rst = 0;

      // directed encodings, junk in unused fields
      send(3'd1, 7'h13, 3'd0, 7'h55, 5'd1, 5'd0, 5'd9,
           32'd5, 1, 32'h00500093);
      chk("latency_valid", 32'(out_valid), 1);
      send(3'd3, 7'h23, 3'd2, 7'h55, 5'd17, 5'd1, 5'd2,
           32'd8, 1, 32'h0020A423);
      send(3'd2, 7'h63, 3'd0, 7'h55, 5'd3, 5'd0, 5'd0,
           32'hFFFFFFFC, 1, 32'hFE000EE3);
      send(3'd4, 7'h6F, 3'd5, 7'h55, 5'd1, 5'd7, 5'd9,
           32'd8, 1, 32'h008000EF);
      send(3'd5, 7'h37, 3'd6, 7'h55, 5'd5, 5'd31, 5'd31,
           32'h12345000, 1, 32'h123452B7);

      // range errors
      send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0,
           32'h800, 0, 32'h0);
      chk("rej_no_valid", 32'(out_valid), 0);
      chk("rej_err", 32'(err), 1);
      chk("rej_err_cnt", 32'(err_cnt), 1);
      send(3'd0, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2,
           32'h0, 0, 32'h0);
      chk("addr_after_rej", 32'(out_addr), 5);
      send(3'd2, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0,
           32'd3, 0, 32'h0);
      chk("rej2_err_cnt", 32'(err_cnt), 2);
      clr_err = 1;
      send(3'd4, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0,
           32'h00100000, 0, 32'h0);
      chk("clr_rej_err", 32'(err), 1);
      chk("clr_rej_cnt", 32'(err_cnt), 1);
      pulse_clr();
      chk("clr_err", 32'(err), 0);
      chk("clr_err_cnt", 32'(err_cnt), 0);
      drain();
      chk("word_cnt_a", 32'(word_cnt), 32'(m_pushed));

      // backpressure
      out_ready = 0;
      send(3'd1, 7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0,
           32'hFFFFFFFF, 0, 32'h0);
      drive(3'd0, 7'h33, 3'd4, 7'h00, 5'd4, 5'd5, 5'd6, 32'h0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(in_ready), 0);
         chk("bp_valid", 32'(out_valid), 1);
         chk("bp_inst", out_inst, 32'hFFF00113);
         chk("bp_addr", 32'(out_addr), 6);
      end
      step();
      out_ready = 1;
      wait_accept(0, 32'h0);
      drain();
      chk("word_cnt_bp", 32'(word_cnt), 32'(m_pushed));

      // address wrap and load
      load_base(8'hFE);
      for (int i = 0; i < 3; i++)
         send(3'd0, 7'h33, 3'd0, 7'h00, 5'(i), 5'd1, 5'd2,
              32'h0, 0, 32'h0);
      chk("wrap_addr", 32'(out_addr), 32'h00);
      base_load = 1;
      base_addr = 8'h40;
      send(3'd0, 7'h33, 3'd1, 7'h00, 5'd8, 5'd1, 5'd2,
           32'h0, 0, 32'h0);
      chk("bl_same_cycle", 32'(out_addr), 32'h01);
      send(3'd0, 7'h33, 3'd2, 7'h00, 5'd9, 5'd1, 5'd2,
           32'h0, 0, 32'h0);
      chk("bl_next", 32'(out_addr), 32'h40);
      drain();

      // random traffic with random backpressure
      pulse_clr();
      rnd_ready = 1;
      for (int n = 0; n < 300; n++) begin
         send_rand();
         if ($urandom_range(0, 3) == 0) step();
      end
      rnd_ready = 0;
      drain();
      chk("rnd_err", 32'(err), 32'(m_err));
      chk("rnd_err_cnt", 32'(err_cnt), 32'(m_err_cnt));
      chk("rnd_word_cnt", 32'(word_cnt), 32'(m_pushed));

      // reset mid-operation
      send(3'd5, 7'h37, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0,
           32'h00000123, 0, 32'h0);
      out_ready = 0;
      send(3'd0, 7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3,
           32'h0, 0, 32'h0);
      @(negedge clk);
      chk("pre_rst_valid", 32'(out_valid), 1);
      #2;
      rst = 1;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 0);
      chk("mid_rst_err", 32'(err), 0);
      chk("mid_rst_err_cnt", 32'(err_cnt), 0);
      chk("mid_rst_word_cnt", 32'(word_cnt), 0);
      model_reset();
      step();
      rst = 0;
      out_ready = 1;
      send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0,
           32'd5, 0, 32'h0);
      chk("post_rst_addr", 32'(out_addr), 0);
      drain();
      chk("post_rst_words", 32'(word_cnt), 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
